// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet iteration controller.
//   iter_state_t     : controller state encoding
//   MAXNET_N         : default neuron count
//   MAXNET_MAX_ITER  : default pass limit before timeout
//   clog2()          : ceil(log2(v)), minimum 1, usable in constant expressions
package maxnet_pkg;

  localparam int unsigned MAXNET_N        = 4;
  localparam int unsigned MAXNET_MAX_ITER = 15;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StInit = 3'd1,
    StRun  = 3'd2,
    StWait = 3'd3,
    StEval = 3'd4,
    StFeed = 3'd5,
    StFin  = 3'd6
  } iter_state_t;

  // Minimum of 1 so that a width derived from it is never zero.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/maxnet_iter_ctrl_if.sv
// Signal bundle between the Maxnet iteration controller and its surroundings
// (host, PLU controller and activation datapath).
//   master : the controller  -- drives strobes, status and results
//   slave  : the environment -- drives start, plu_done and act_nz
interface maxnet_iter_ctrl_if
  import maxnet_pkg::*;
#(
  parameter int unsigned N   = MAXNET_N,
  parameter int unsigned ITW = 4
);

  localparam int unsigned IW = clog2(N);

  logic           start;
  logic           init_ld;
  logic           plu_start;
  logic           plu_done;
  logic [N-1:0]   act_nz;
  logic           fb_ld;
  logic           busy;
  logic           done;
  logic [IW-1:0]  winner;
  logic           no_winner;
  logic           timeout;
  logic [ITW-1:0] iter_cnt;

  modport master (
    input  start, plu_done, act_nz,
    output init_ld, plu_start, fb_ld, busy, done, winner, no_winner, timeout, iter_cnt
  );

  modport slave (
    output start, plu_done, act_nz,
    input  init_ld, plu_start, fb_ld, busy, done, winner, no_winner, timeout, iter_cnt
  );

endinterface

// File: rtl/nz_eval.sv
// Combinational evaluation of the per-neuron nonzero flags.
//   act_nz : N flags, bit i set when neuron i is still active
//   cnt    : number of set flags
//   idx    : index of the lowest set flag (0 when none set)
module nz_eval
  import maxnet_pkg::*;
#(
  parameter int unsigned N = MAXNET_N
) (
  input  logic [N-1:0]           act_nz,
  output logic [clog2(N+1)-1:0]  cnt,
  output logic [clog2(N)-1:0]    idx
);

  localparam int unsigned CW = clog2(N + 1);
  localparam int unsigned IW = clog2(N);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      cnt = cnt + CW'(act_nz[i]);
    end
  end

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (act_nz[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/maxnet_iter_ctrl.sv
// Maxnet iteration controller: runs the PLU pass by pass until one neuron
// survives, all die, or MAX_ITER passes have been made.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, aborts a run without done
//   bus  : master side of maxnet_iter_ctrl_if
//          in : start, plu_done, act_nz
//          out: init_ld, plu_start, fb_ld, busy, done (Moore strobes)
//               winner, no_winner, timeout, iter_cnt (registered results)
module maxnet_iter_ctrl
  import maxnet_pkg::*;
#(
  parameter int unsigned N        = MAXNET_N,
  parameter int unsigned MAX_ITER = MAXNET_MAX_ITER,
  parameter int unsigned ITW      = 4
) (
  input  logic                clk,
  input  logic                rst,
  maxnet_iter_ctrl_if.master  bus
);

  localparam int unsigned CW = clog2(N + 1);
  localparam int unsigned IW = clog2(N);
  localparam logic [ITW-1:0] MaxIter = ITW'(MAX_ITER);

  iter_state_t state_q, state_d;

  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;

  logic [ITW-1:0] iter_cnt_q, iter_cnt_d, iter_inc;
  logic [IW-1:0]  winner_q, winner_d;
  logic           no_winner_q, no_winner_d;
  logic           timeout_q, timeout_d;

  logic           is_one, is_zero, at_limit;
  logic           init_ld, plu_start, fb_ld, busy, done;

  nz_eval #(
    .N (N)
  ) u_nz_eval (
    .act_nz (bus.act_nz),
    .cnt    (cnt),
    .idx    (idx)
  );

  // Saturating pass count; the FSM stops at MAX_ITER, saturation is a backstop.
  assign iter_inc = (iter_cnt_q == MaxIter) ? iter_cnt_q : iter_cnt_q + ITW'(1);
  assign is_one   = (cnt == CW'(1));
  assign is_zero  = (cnt == '0);
  assign at_limit = (iter_inc == MaxIter);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (bus.start) state_d = StInit;
      StInit: state_d = StRun;
      StRun:  state_d = StWait;
      StWait: if (bus.plu_done) state_d = StEval;
      StEval: begin
        if (is_one || is_zero || at_limit) state_d = StFin;
        else                               state_d = StFeed;
      end
      StFeed: state_d = StRun;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs
  always_comb begin
    init_ld   = 1'b0;
    plu_start = 1'b0;
    fb_ld     = 1'b0;
    done      = 1'b0;
    busy      = (state_q != StIdle);
    case (state_q)
      StInit:  init_ld   = 1'b1;
      StRun:   plu_start = 1'b1;
      StFeed:  fb_ld     = 1'b1;
      StFin:   done      = 1'b1;
      default: ;
    endcase
  end

  // Result registers: cleared in INIT, written once per pass in EVAL.
  always_comb begin
    iter_cnt_d  = iter_cnt_q;
    winner_d    = winner_q;
    no_winner_d = no_winner_q;
    timeout_d   = timeout_q;
    if (state_q == StInit) begin
      iter_cnt_d  = '0;
      winner_d    = '0;
      no_winner_d = 1'b0;
      timeout_d   = 1'b0;
    end else if (state_q == StEval) begin
      iter_cnt_d = iter_inc;
      if (is_one)        winner_d    = idx;
      else if (is_zero)  no_winner_d = 1'b1;
      else if (at_limit) timeout_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt_q  <= '0;
      winner_q    <= '0;
      no_winner_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      iter_cnt_q  <= iter_cnt_d;
      winner_q    <= winner_d;
      no_winner_q <= no_winner_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.init_ld   = init_ld;
  assign bus.plu_start = plu_start;
  assign bus.fb_ld     = fb_ld;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.winner    = winner_q;
  assign bus.no_winner = no_winner_q;
  assign bus.timeout   = timeout_q;
  assign bus.iter_cnt  = iter_cnt_q;

endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// Bench for maxnet_iter_ctrl with N=4, MAX_ITER=3. A cycle-stepped PLU model
// answers each plu_start with plu_done 4 cycles later and presents the next
// act_nz pattern only in the cycle after plu_done (junk otherwise).
module tb_maxnet_iter_ctrl;

  typedef struct packed {
    logic [15:0] nz;        // nibble k = act_nz for pass k
    logic [1:0]  winner;
    logic        no_winner;
    logic        timeout;
    logic [3:0]  iter;
    logic [7:0]  fb;
    logic [7:0]  ps;
    logic [7:0]  lat;
  } vec_t;

  logic clk;
  logic rst;

  maxnet_iter_ctrl_if #(.N(4), .ITW(4)) bus ();

  maxnet_iter_ctrl #(
    .N        (4),
    .MAX_ITER (3),
    .ITW      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  vec_t sb_q[$];
  vec_t tab[7];

  int          timer;
  bit          prev_done;
  int          pass;
  logic [15:0] cur_seq;
  bit          spur;
  int          n_fb, n_ps, n_done, n_init;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Advance one cycle, sample outputs at posedge+1 and drive the PLU side.
  task automatic step();
    @(posedge clk);
    #1;
    bus.plu_done = 1'b0;
    if (prev_done && pass < 4) begin
      bus.act_nz = cur_seq[pass*4 +: 4];
      pass++;
    end else begin
      bus.act_nz = 4'b1111;
    end
    prev_done = 1'b0;
    if (bus.init_ld)   n_init++;
    if (bus.fb_ld)     n_fb++;
    if (bus.done)      n_done++;
    if (timer > 0) begin
      timer--;
      if (timer == 0) begin
        bus.plu_done = 1'b1;
        prev_done    = 1'b1;
      end
    end
    if (bus.plu_start) begin
      n_ps++;
      timer = 4;
      if (spur) bus.plu_done = 1'b1;
    end
  endtask

  task automatic clear_model();
    timer = 0; prev_done = 1'b0; pass = 0;
    n_fb = 0; n_ps = 0; n_done = 0; n_init = 0;
  endtask

  task automatic run_vec(input vec_t v, input bit hold);
    vec_t e;
    int   lat;
    int   cyc;
    sb_q.push_back(v);
    clear_model();
    cur_seq   = v.nz;
    lat       = -1;
    cyc       = 0;
    bus.start = 1'b1;
    while (lat < 0 && cyc < 200) begin
      step();
      cyc++;
      if (!hold) bus.start = 1'b0;
      if (bus.done) lat = cyc;
    end
    e = sb_q.pop_front();
    check("done_seen", 32'(lat >= 0), 32'd1);
    check("winner", 32'(bus.winner), 32'(e.winner));
    check("no_winner", 32'(bus.no_winner), 32'(e.no_winner));
    check("timeout", 32'(bus.timeout), 32'(e.timeout));
    check("iter_cnt", 32'(bus.iter_cnt), 32'(e.iter));
    check("latency", 32'(lat), 32'(e.lat));
    check("fb_ld_pulses", 32'(n_fb), 32'(e.fb));
    check("plu_start_pulses", 32'(n_ps), 32'(e.ps));
    check("init_ld_pulses", 32'(n_init), 32'd1);
    if (hold) begin
      step();
      check("idle_after_fin", 32'(bus.busy), 32'd0);
      step();
      check("restart_from_idle", 32'(bus.init_ld), 32'd1);
      check("single_done_hold", 32'(n_done), 32'd1);
      bus.start = 1'b0;
      rst       = 1'b1;
      step();
      rst   = 1'b0;
      timer = 0;
    end else begin
      repeat (3) step();
      check("single_done", 32'(n_done), 32'd1);
      check("busy_idle", 32'(bus.busy), 32'd0);
      check("winner_hold", 32'(bus.winner), 32'(e.winner));
      check("iter_hold", 32'(bus.iter_cnt), 32'(e.iter));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_init_ld"}, 32'(bus.init_ld), 32'd0);
    check({tag, "_plu_start"}, 32'(bus.plu_start), 32'd0);
    check({tag, "_fb_ld"}, 32'(bus.fb_ld), 32'd0);
    check({tag, "_winner"}, 32'(bus.winner), 32'd0);
    check({tag, "_no_winner"}, 32'(bus.no_winner), 32'd0);
    check({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
    check({tag, "_iter_cnt"}, 32'(bus.iter_cnt), 32'd0);
  endtask

  initial begin
    int k;
    //               nz         win    nw    to    iter   fb    ps    lat
    tab[0] = '{16'h0004, 2'd2, 1'b0, 1'b0, 4'd1, 8'd0, 8'd1, 8'd8};
    tab[1] = '{16'h089B, 2'd3, 1'b0, 1'b0, 4'd3, 8'd2, 8'd3, 8'd22};
    tab[2] = '{16'h0000, 2'd0, 1'b1, 1'b0, 4'd1, 8'd0, 8'd1, 8'd8};
    tab[3] = '{16'h0333, 2'd0, 1'b0, 1'b1, 4'd3, 8'd2, 8'd3, 8'd22};
    tab[4] = '{16'h0016, 2'd0, 1'b0, 1'b0, 4'd2, 8'd1, 8'd2, 8'd15};
    tab[5] = '{16'h000F, 2'd0, 1'b1, 1'b0, 4'd2, 8'd1, 8'd2, 8'd15};
    tab[6] = '{16'h0008, 2'd3, 1'b0, 1'b0, 4'd1, 8'd0, 8'd1, 8'd8};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.plu_done = 1'b0;
    bus.act_nz   = 4'b0000;
    spur         = 1'b0;
    cur_seq      = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < 7; i++) begin
      run_vec(tab[i], 1'b0);
    end

    // Reset during WAIT of pass 2, then a stray plu_done while idle.
    clear_model();
    cur_seq   = 16'h009B;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    k = 0;
    while (n_ps < 2 && k < 100) begin
      step();
      k++;
    end
    check("reach_pass2", 32'(n_ps), 32'd2);
    step();
    step();
    check("in_wait_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    rst   = 1'b0;
    timer = 0;
    check_reset_outputs("midrun_rst");
    bus.plu_done = 1'b1;
    step();
    repeat (3) step();
    check("stray_done_busy", 32'(bus.busy), 32'd0);
    check("rst_no_done", 32'(n_done), 32'd0);
    check("rst_no_plu_start", 32'(n_ps), 32'd2);
    run_vec(tab[0], 1'b0);

    // start held throughout, spurious plu_done in RUN.
    spur = 1'b1;
    run_vec(tab[0], 1'b1);
    spur = 1'b0;
    check_reset_outputs("after_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxnet_iter_ctrl.md
# maxnet_iter_ctrl

Iteration controller for the Maxnet network: runs the PLU repeatedly until exactly one neuron stays active. It sits directly upstream of the PLU controller, driving its `start` and consuming its `done`. It also drives the activation-register load strobes in the datapath. After each PLU pass it evaluates the per-neuron nonzero flags and decides whether to finish or feed results back for another pass.

## Interface
Parameters:
- `N`, 4: number of neurons (≥2).
- `MAX_ITER`, 15: maximum PLU passes before timeout (≥1).
- `ITW`, 4: iteration counter width; must hold `MAX_ITER`.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a Maxnet run; sampled only in IDLE.
- `init_ld`  out  1  one-cycle strobe: load external inputs into activation registers.
- `plu_start`  out  1  one-cycle start pulse to the PLU controller.
- `plu_done`  in  1  PLU pass complete; honoured only in WAIT.
- `act_nz`  in  N  per-neuron "activation > 0" flags from the datapath, valid the cycle after `plu_done`.
- `fb_ld`  out  1  one-cycle strobe: load PLU outputs back into activation registers.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `winner`  out  $clog2(N)  index of the surviving neuron.
- `no_winner`  out  1  all activations reached zero.
- `timeout`  out  1  `MAX_ITER` passes done with more than one neuron active.
- `iter_cnt`  out  ITW  number of completed PLU passes in the current or last run.

## Operation
- States: IDLE, INIT, RUN, WAIT, EVAL, FEED, FIN.
- IDLE: if `start` then INIT; otherwise stay.
- INIT: `init_ld`=1; clear `iter_cnt`, `winner`, `no_winner`, `timeout`; go to RUN.
- RUN: `plu_start`=1; go to WAIT.
- WAIT: stay until `plu_done`; then go to EVAL.
- EVAL: sample `act_nz`, increment `iter_cnt`, then branch on `cnt`, the popcount of `act_nz`:
  - `cnt`==1: set `winner` to the set bit's index; go to FIN.
  - `cnt`==0: set `no_winner`; go to FIN.
  - `cnt`≥2 and incremented `iter_cnt`==`MAX_ITER`: set `timeout`; go to FIN.
  - otherwise go to FEED.
- FEED: `fb_ld`=1; go to RUN.
- FIN: `done`=1; go to IDLE.
- Outputs are Moore-decoded from state, except the registered results (`winner`, `no_winner`, `timeout`, `iter_cnt`). Results hold until the next INIT.
- Exactly one of `winner` valid, `no_winner`, or `timeout` describes each run. `winner` stays 0 unless `cnt`==1.
- Invalid state encoding: go to IDLE.

## Timing
- Reset values: state IDLE; all strobes 0; `busy`, `done`, `no_winner`, `timeout` = 0; `winner`=0; `iter_cnt`=0.
- `rst` asserted mid-run aborts at the next edge with no `done`. The PLU is reset by the same `rst`.
- `start` is sampled in cycle 0.
  - INIT is cycle 1 and RUN is cycle 2.
  - The PLU reaches S1 at cycle 3 and asserts done at cycle 6.
  - EVAL is cycle 7 and FIN (`done`) is cycle 8.
- Single-pass latency from `start` to `done` is 8 cycles. Each extra pass adds 7 cycles (FEED, RUN, 4×WAIT, EVAL).
- `start` while `busy`: ignored, not queued. `start` during FIN: ignored; a new run needs `start` in IDLE.
- `plu_done` outside WAIT: ignored.
- `plu_start` is never reasserted before the PLU has returned to S0. The EVAL+FEED gap guarantees this.
- `iter_cnt` saturates at `MAX_ITER` and never wraps.

## Structure
- Shared package `maxnet_pkg`:
  - state enum `iter_state_t`;
  - default constants `MAXNET_N`, `MAXNET_MAX_ITER`;
  - helper function `clog2` if the toolflow lacks `$clog2`.
- Sub-module `nz_eval`: combinational popcount of `act_nz` plus a one-hot-to-index encoder. Outputs `cnt` (width `$clog2(N+1)`) and `idx` (lowest set index).

## Test plan
- Reset, then `start`; PLU model returns done 4 cycles after `plu_start`; `act_nz`=4'b0100 → `done` at cycle 8, `winner`=2, `iter_cnt`=1, flags 0.
- `act_nz` sequence 4'b1011, 4'b1001, 4'b1000 → 2 `fb_ld` pulses, `winner`=3, `iter_cnt`=3, `done` at cycle 22.
- `act_nz`=4'b0000 on first pass → `no_winner`=1, `winner`=0, `iter_cnt`=1.
- `MAX_ITER`=3 with `act_nz`=4'b0011 every pass → `timeout`=1, `iter_cnt`=3, exactly 2 `fb_ld` pulses, 3 `plu_start` pulses.
- `rst` pulsed while in WAIT of pass 2 → all outputs at reset values next cycle, no `done`; a stray `plu_done` afterward is ignored. A fresh `start` then completes normally.
- `start` held high throughout a run, plus a spurious `plu_done` in RUN → no extra `plu_start`, single `done`, next run begins only from IDLE.
